// File: rtl/mux_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mux_bist_ctrl
//
// Self-test engine for a 3-input select cell (z = c ? b : a).
//
// The engine drives the cell's a, b and c inputs and samples its z output. It
// applies all eight {a,b,c} vectors in ascending order and checks each
// response against the golden select function. It reports an overall pass
// flag, a saturating mismatch count, and the first vector that mismatched.
//
// Each vector is held for SETTLE_CYCLES cycles (SETTLE). z is then compared
// for one cycle (CHECK). A full sweep therefore takes 8*(SETTLE_CYCLES+1)
// cycles.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before z is sampled (>= 1)
//   CNT_W          width of fail_count (>= 1)
//
// Ports
//   clk               in   single clock, rising edge
//   rst_n             in   synchronous active-low reset
//   start             in   launch a sweep (honoured in IDLE and DONE)
//   abort             in   cancel a running sweep
//   dut_a/dut_b/dut_c out  registered stimulus {a,b,c} = vec[2:0]
//   dut_z             in   response from the cell under test
//   busy              out  sweep in progress
//   done              out  sweep finished; held until the next start
//   pass              out  done with no mismatches
//   fail_count        out  number of mismatching vectors, saturating
//   first_fail_vec    out  {a,b,c} of the first mismatch
//   first_fail_valid  out  first_fail_vec holds a captured vector
// -----------------------------------------------------------------------------
module mux_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    // The settle counter must be at least 1 bit wide, even when SETTLE_CYCLES == 1.
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic [2:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;

    logic exp_z;
    logic mismatch;

    // Golden select function, evaluated on the vector currently driven.
    assign exp_z = vec_q[0] ? vec_q[1] : vec_q[2];

    // The case inequality makes an X or Z on dut_z count as a mismatch.
    // Synthesis treats it as a plain inequality, and a real net is never X.
    assign mismatch = (dut_z !== exp_z);

    // ------------------------------------------------------------------------
    // Next-state and next-result logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here receives a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_count_d = fail_count_q;
        ffv_d        = ffv_q;
        ffvalid_d    = ffvalid_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A new start clears the previous results and restarts at vector 0.
                // In these states abort is ignored, so start wins when both are high.
                if (start) begin
                    state_d      = SETTLE;
                    vec_d        = 3'd0;
                    cnt_d        = SETTLE_LOAD;
                    fail_count_d = '0;
                    ffv_d        = 3'd0;
                    ffvalid_d    = 1'b0;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            CHECK: begin
                // An abort in this cycle discards the comparison result.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        if (fail_count_q != CNT_MAX) begin
                            fail_count_d = fail_count_q + 1'b1;
                        end
                        if (!ffvalid_q) begin
                            ffv_d     = vec_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    // After the last vector, the stimulus keeps driving 3'b111.
                    if (vec_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 3'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = SETTLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples the values from before the edge, whatever
        // order the statements appear in.
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 3'd0;
            cnt_q        <= '0;
            fail_count_q <= '0;
            ffv_q        <= 3'd0;
            ffvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_count_q <= fail_count_d;
            ffv_q        <= ffv_d;
            ffvalid_q    <= ffvalid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The stimulus comes straight from the vector register, so it is glitch-free.
    // It keeps its value through an abort.
    assign dut_a = vec_q[2];
    assign dut_b = vec_q[1];
    assign dut_c = vec_q[0];

    assign busy             = (state_q == SETTLE) || (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign pass             = done && (fail_count_q == '0);
    assign fail_count       = fail_count_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_bist_ctrl
//
// Bench for mux_bist_ctrl. It instantiates three configurations:
//   u0: SETTLE_CYCLES=1, CNT_W=4
//   u1: SETTLE_CYCLES=1, CNT_W=2
//   u2: SETTLE_CYCLES=3, CNT_W=4
// A behavioural cell model drives each dut_z. Its mode selects the behaviour:
//   0: correct cell
//   1: z stuck at 0
//   2: select inverted
//   3: inverted output
// The sweep runs come from a record table. Hand-written sequences cover reset,
// abort and restart.
// -----------------------------------------------------------------------------
module tb_mux_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [2:0] abort;
    logic [2:0] dut_a, dut_b, dut_c, dut_z;
    logic [2:0] busy, done, pass, ffvalid;
    logic [3:0] fc0, fc2;
    logic [1:0] fc1;
    logic [2:0] ffv [3];
    int         mode [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    function automatic logic model_z(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return c ? b : a;
            1:       return 1'b0;
            2:       return c ? a : b;
            default: return ~(c ? b : a);
        endcase
    endfunction

    assign dut_z[0] = model_z(mode[0], dut_a[0], dut_b[0], dut_c[0]);
    assign dut_z[1] = model_z(mode[1], dut_a[1], dut_b[1], dut_c[1]);
    assign dut_z[2] = model_z(mode[2], dut_a[2], dut_b[2], dut_c[2]);

    mux_bist_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_c(dut_c[0]), .dut_z(dut_z[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_count(fc0),
        .first_fail_vec(ffv[0]), .first_fail_valid(ffvalid[0]));

    mux_bist_ctrl #(.SETTLE_CYCLES(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_c(dut_c[1]), .dut_z(dut_z[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_count(fc1),
        .first_fail_vec(ffv[1]), .first_fail_valid(ffvalid[1]));

    mux_bist_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .dut_a(dut_a[2]), .dut_b(dut_b[2]), .dut_c(dut_c[2]), .dut_z(dut_z[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail_count(fc2),
        .first_fail_vec(ffv[2]), .first_fail_valid(ffvalid[2]));

    typedef struct {
        int idx;
        int mode;
        int settle;
        int exp_done_n;
        int exp_fc;
        int exp_fv;
        int exp_valid;
        int exp_pass;
    } sweep_rec_t;

    sweep_rec_t tbl [5];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int get_fc(input int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2);
        endcase
    endfunction

    function automatic int get_vec(input int i);
        return int'({dut_a[i], dut_b[i], dut_c[i]});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts instance i and follows the sweep until done, within a cycle budget.
    // Sample n is the first sample after start's edge T plus (n-1) edges.
    // On return, done_n is the sample on which done first read 1, or 0 if it
    // never did. seq_err counts the samples on which the stimulus was not the
    // expected vector.
    task automatic run_sweep(input int i, input int settle, input int restart_at,
                             output int done_n, output int seq_err);
        int exp_vec;
        done_n  = 0;
        seq_err = 0;
        start[i] = 1'b1;
        step();
        for (int n = 1; n <= 200; n++) begin
            start[i] = (n == restart_at);
            exp_vec = (n - 1) / (settle + 1);
            if (exp_vec > 7) exp_vec = 7;
            if (get_vec(i) != exp_vec) seq_err++;
            if (done[i]) begin
                done_n = n;
                break;
            end
            step();
        end
        start[i] = 1'b0;
    endtask

    initial begin
        int dn, se;

        //            idx mode settle done_n fc fv valid pass
        tbl[0] = '{0, 0, 1, 17, 0, 0, 0, 1};
        tbl[1] = '{0, 1, 1, 17, 4, 3, 1, 0};
        tbl[2] = '{0, 2, 1, 17, 4, 2, 1, 0};
        tbl[3] = '{1, 3, 1, 17, 3, 0, 1, 0};
        tbl[4] = '{2, 0, 3, 33, 0, 0, 0, 1};

        start = '0;
        abort = '0;
        mode  = '{0, 0, 0};
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_busy",  int'(busy),    0);
        check("rst_done",  int'(done),    0);
        check("rst_pass",  int'(pass),    0);
        check("rst_fc0",   get_fc(0),     0);
        check("rst_vec0",  get_vec(0),    0);
        check("rst_ffv0",  int'(ffv[0]),  0);
        check("rst_valid", int'(ffvalid), 0);

        // Table-driven full sweeps
        foreach (tbl[k]) begin
            mode[tbl[k].idx] = tbl[k].mode;
            run_sweep(tbl[k].idx, tbl[k].settle, 0, dn, se);
            check($sformatf("t%0d_done_n", k), dn, tbl[k].exp_done_n);
            check($sformatf("t%0d_vec_seq_err", k), se, 0);
            check($sformatf("t%0d_fail_count", k), get_fc(tbl[k].idx), tbl[k].exp_fc);
            check($sformatf("t%0d_first_vec", k), int'(ffv[tbl[k].idx]), tbl[k].exp_fv);
            check($sformatf("t%0d_first_valid", k), int'(ffvalid[tbl[k].idx]), tbl[k].exp_valid);
            check($sformatf("t%0d_pass", k), int'(pass[tbl[k].idx]), tbl[k].exp_pass);
            check($sformatf("t%0d_busy", k), int'(busy[tbl[k].idx]), 0);
        end

        // u2: a start while busy (sampled at T+5) is ignored. A start from DONE
        // then clears the results and reruns the sweep.
        mode[2] = 1;
        run_sweep(2, 3, 5, dn, se);
        check("rb_done_n",   dn, 33);
        check("rb_seq_err",  se, 0);
        check("rb_fc",       get_fc(2), 4);
        check("rb_first",    int'(ffv[2]), 3);
        mode[2] = 0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        check("rs_busy",  int'(busy[2]), 1);
        check("rs_done",  int'(done[2]), 0);
        check("rs_fc",    get_fc(2), 0);
        check("rs_valid", int'(ffvalid[2]), 0);
        for (int k = 0; k < 100 && !done[2]; k++) step();
        check("rs_pass",  int'(pass[2]), 1);

        // u0: reset during vector 4 with z stuck at 0
        mode[0] = 1;
        start[0] = 1'b1;
        step();                       // n=1
        start[0] = 1'b0;
        repeat (8) step();            // n=9: vector 4 settling
        check("mr_vec_pre", get_vec(0), 4);
        check("mr_fc_pre",  get_fc(0), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_busy",  int'(busy[0]), 0);
        check("mr_done",  int'(done[0]), 0);
        check("mr_vec",   get_vec(0), 0);
        check("mr_fc",    get_fc(0), 0);
        check("mr_ffv",   int'(ffv[0]), 0);
        check("mr_valid", int'(ffvalid[0]), 0);

        // u0: abort during vector 5 with z stuck at 0
        start[0] = 1'b1;
        step();                       // n=1
        start[0] = 1'b0;
        repeat (10) step();           // n=11: vector 5 settling
        check("ab_vec_pre", get_vec(0), 5);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("ab_busy",  int'(busy[0]), 0);
        check("ab_done",  int'(done[0]), 0);
        check("ab_pass",  int'(pass[0]), 0);
        check("ab_fc",    get_fc(0), 2);
        check("ab_ffv",   int'(ffv[0]), 3);
        check("ab_valid", int'(ffvalid[0]), 1);
        check("ab_vec",   get_vec(0), 5);

        // An abort in IDLE has no effect
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("ai_busy", int'(busy[0]), 0);
        check("ai_fc",   get_fc(0), 2);

        // With start and abort both high in IDLE, start wins
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step();                       // n=1
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("sa_busy", int'(busy[0]), 1);
        check("sa_fc",   get_fc(0), 0);

        // An abort in the CHECK cycle of vector 6 discards that mismatch
        repeat (13) step();           // n=14: vector 6 CHECK
        check("ac_vec_pre", get_vec(0), 6);
        check("ac_fc_pre",  get_fc(0), 2);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("ac_fc",   get_fc(0), 2);
        check("ac_busy", int'(busy[0]), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
